// File: rtl/sprite_pkg.sv
// Shared sprite attribute types, the scanner state encoding and the sprite enable rule.
package sprite_pkg;

  localparam int unsigned SPR_COORD_W = 8;
  // Edge coordinates carry one extra bit so that x+w and y+h never wrap.
  localparam int unsigned SPR_EDGE_W  = SPR_COORD_W + 1;

  // Field order matches the spr_data layout {x, y, w, h}.
  typedef struct packed {
    logic [SPR_COORD_W-1:0] x;
    logic [SPR_COORD_W-1:0] y;
    logic [SPR_COORD_W-1:0] w;
    logic [SPR_COORD_W-1:0] h;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_CAP_A,
    ST_RD_B,
    ST_CAP_B,
    ST_CHK,
    ST_EMIT,
    ST_DONE
  } scan_state_t;

  // A sprite with zero width or zero height is disabled.
  function automatic logic spr_enabled(sprite_attr_t s);
    return (s.w != '0) && (s.h != '0);
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational inclusive bounding-box overlap test between two sprites.
// Ports:
//   a, b : sprite attributes
//   hit  : both sprites enabled and their boxes overlap (touching edges count)
module rect_overlap
  import sprite_pkg::*;
(
  input  sprite_attr_t a,
  input  sprite_attr_t b,
  output logic         hit
);

  logic [SPR_EDGE_W-1:0] ax1, ay1, ax2, ay2;
  logic [SPR_EDGE_W-1:0] bx1, by1, bx2, by2;
  logic                  h_ov, v_ov;

  // Far edges in 9 bits, so a sprite near 255 extends past the 8-bit range.
  always_comb begin
    ax1  = SPR_EDGE_W'(a.x);
    ay1  = SPR_EDGE_W'(a.y);
    bx1  = SPR_EDGE_W'(b.x);
    by1  = SPR_EDGE_W'(b.y);
    ax2  = ax1 + SPR_EDGE_W'(a.w);
    ay2  = ay1 + SPR_EDGE_W'(a.h);
    bx2  = bx1 + SPR_EDGE_W'(b.w);
    by2  = by1 + SPR_EDGE_W'(b.h);
    h_ov = (ax1 <= bx2) && (bx1 <= ax2);
    v_ov = (ay1 <= by2) && (by1 <= ay2);
    hit  = h_ov && v_ov && spr_enabled(a) && spr_enabled(b);
  end

endmodule

// File: rtl/collision_scanner.sv
// Sequential pairwise collision scanner over the sprite attribute table.
// Reads every pair (i<j) through a one-cycle-latency read port and streams
// colliding pairs out over valid/ready, in (i, j) lexicographic order.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a scan (accepted only when idle)
//   busy, done          : scan in progress / one-cycle end-of-scan pulse
//   spr_rd, spr_addr    : attribute read strobe and index
//   spr_data            : attribute data, valid the cycle after spr_rd
//   hit_valid/hit_ready : colliding pair handshake
//   hit_a, hit_b        : lower / higher index of the colliding pair
//   hit_count           : saturating count of hits emitted this scan
module collision_scanner
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPRITES = 8,
  parameter int unsigned IDX_W     = $clog2(N_SPRITES),
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             spr_rd,
  output logic [IDX_W-1:0] spr_addr,
  input  logic [31:0]      spr_data,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [IDX_W-1:0] hit_a,
  output logic [IDX_W-1:0] hit_b,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_SPRITES - 1);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_SPRITES - 2);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  sprite_attr_t     a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             spr_rd_q, spr_rd_d;
  logic [IDX_W-1:0] spr_addr_q, spr_addr_d;
  logic             hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0] hit_a_q, hit_a_d, hit_b_q, hit_b_d;
  logic             pair_hit;
  logic             advance;

  rect_overlap u_overlap (
    .a   (a_q),
    .b   (b_q),
    .hit (pair_hit)
  );

  // Next-state, index and registered-output logic.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    a_d         = a_q;
    b_d         = b_q;
    hit_count_d = hit_count_q;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d         = '0;
          j_d         = IDX_W'(1);
          hit_count_d = '0;
          state_d     = ST_RD_A;
        end
      end
      ST_RD_A:  state_d = ST_CAP_A;
      ST_CAP_A: begin
        a_d     = sprite_attr_t'(spr_data);
        state_d = ST_RD_B;
      end
      ST_RD_B:  state_d = ST_CAP_B;
      ST_CAP_B: begin
        b_d     = sprite_attr_t'(spr_data);
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (pair_hit) state_d = ST_EMIT;
        else          advance = 1'b1;
      end
      ST_EMIT: begin
        if (hit_ready) begin
          advance = 1'b1;
          if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Step to the next pair: next j, else reload A with the next i, else finish.
    if (advance) begin
      if (j_q < LAST_J) begin
        j_d     = j_q + 1'b1;
        state_d = ST_RD_B;
      end else if (i_q < LAST_I) begin
        i_d     = i_q + 1'b1;
        j_d     = i_q + IDX_W'(2);
        state_d = ST_RD_A;
      end else begin
        state_d = ST_DONE;
      end
    end

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    hit_valid_d = (state_d == ST_EMIT);
    spr_rd_d    = (state_d == ST_RD_A) || (state_d == ST_RD_B);
    spr_addr_d  = spr_addr_q;
    if (state_d == ST_RD_A)      spr_addr_d = i_d;
    else if (state_d == ST_RD_B) spr_addr_d = j_d;
    hit_a_d = hit_a_q;
    hit_b_d = hit_b_q;
    if (state_d == ST_EMIT) begin
      hit_a_d = i_q;
      hit_b_d = j_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spr_rd_q    <= 1'b0;
      spr_addr_q  <= '0;
      hit_valid_q <= 1'b0;
      hit_a_q     <= '0;
      hit_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      spr_rd_q    <= spr_rd_d;
      spr_addr_q  <= spr_addr_d;
      hit_valid_q <= hit_valid_d;
      hit_a_q     <= hit_a_d;
      hit_b_q     <= hit_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign spr_rd    = spr_rd_q;
  assign spr_addr  = spr_addr_q;
  assign hit_valid = hit_valid_q;
  assign hit_a     = hit_a_q;
  assign hit_b     = hit_b_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed self-checking bench for collision_scanner with a one-cycle-latency
// attribute memory model and a hit/done monitor.
module tb_collision_scanner;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        spr_rd;
  logic [2:0]  spr_addr;
  logic [31:0] spr_data;
  logic        hit_valid;
  logic        hit_ready;
  logic [2:0]  hit_a;
  logic [2:0]  hit_b;
  logic [7:0]  hit_count;

  logic [31:0] mem [8];
  logic [5:0]  hits [$];
  int          done_cnt;
  int          n_checks;
  int          n_pass;

  collision_scanner #(.N_SPRITES(8), .IDX_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .spr_rd    (spr_rd),
    .spr_addr  (spr_addr),
    .spr_data  (spr_data),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_a     (hit_a),
    .hit_b     (hit_b),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attribute memory: data appears the cycle after the read strobe, junk otherwise.
  always @(posedge clk) begin
    if (spr_rd) spr_data <= mem[spr_addr];
    else        spr_data <= 32'hA5A5_A5A5;
  end

  // Record accepted pairs and done pulses.
  always @(posedge clk) begin
    if (hit_valid && hit_ready) hits.push_back({hit_a, hit_b});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 8; k++) mem[k] = 32'h0;
  endtask

  task automatic set_spr(input int idx, input int x, input int y, input int w, input int h);
    mem[idx] = {8'(x), 8'(y), 8'(w), 8'(h)};
  endtask

  // Pulse (or hold) start and count cycles until done is observed.
  task automatic run_scan(input bit hold_start, output int cyc, output bit timeout);
    hits.delete();
    done_cnt = 0;
    start    = 1'b1;
    cyc      = 0;
    timeout  = 1'b0;
    forever begin
      tick();
      cyc++;
      if (!hold_start) start = 1'b0;
      if (done) break;
      if (cyc > 2000) begin
        timeout = 1'b1;
        break;
      end
    end
    if (!hold_start) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hit_ready = 1'b1;
    clear_mem();
    repeat (3) tick();
    n_checks++; if ({busy, done, spr_rd, hit_valid} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {busy, done, spr_rd, hit_valid}); else n_pass++;
    n_checks++; if ({spr_addr, hit_a, hit_b} !== 9'd0) $display("FAIL reset_idx: got %0h want 0", {spr_addr, hit_a, hit_b}); else n_pass++;
    n_checks++; if (hit_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", hit_count); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_overlap();
    int cyc; bit to;
    clear_mem();
    set_spr(0, 10, 10, 8, 8);
    set_spr(3, 15, 12, 8, 8);
    run_scan(1'b0, cyc, to);
    n_checks++; if (to) $display("FAIL overlap_timeout: got timeout want done"); else n_pass++;
    n_checks++; if (hits.size() !== 1) $display("FAIL overlap_nhits: got %0d want 1", hits.size()); else n_pass++;
    n_checks++; if (hits.size() < 1 || hits[0] !== {3'd0, 3'd3}) $display("FAIL overlap_pair: got %0h want %0h", (hits.size() > 0) ? hits[0] : 6'h3f, {3'd0, 3'd3}); else n_pass++;
    n_checks++; if (cyc !== 100) $display("FAIL overlap_latency: got %0d want 100", cyc); else n_pass++;
    tick();
    n_checks++; if (hit_count !== 8'd1) $display("FAIL overlap_count: got %0d want 1", hit_count); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL overlap_done: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL overlap_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_touch_edge();
    int cyc; bit to;
    clear_mem();
    set_spr(1, 0, 0, 10, 10);
    set_spr(2, 10, 0, 5, 5);
    run_scan(1'b0, cyc, to);
    tick();
    n_checks++; if (hits.size() !== 1 || hits[0] !== {3'd1, 3'd2}) $display("FAIL touch_pair: got n=%0d first=%0h want n=1 first=%0h", hits.size(), (hits.size() > 0) ? hits[0] : 6'h3f, {3'd1, 3'd2}); else n_pass++;
    n_checks++; if (hit_count !== 8'd1) $display("FAIL touch_count: got %0d want 1", hit_count); else n_pass++;
    set_spr(2, 11, 0, 5, 5);
    run_scan(1'b0, cyc, to);
    tick();
    n_checks++; if (hits.size() !== 0) $display("FAIL gap_nhits: got %0d want 0", hits.size()); else n_pass++;
    n_checks++; if (hit_count !== 8'd0) $display("FAIL gap_count: got %0d want 0", hit_count); else n_pass++;
    n_checks++; if (to || cyc !== 99) $display("FAIL nohit_latency: got %0d want 99", cyc); else n_pass++;
  endtask

  task automatic test_no_wrap();
    int cyc; bit to;
    clear_mem();
    set_spr(0, 250, 0, 20, 4);
    set_spr(1, 5, 0, 4, 4);
    run_scan(1'b0, cyc, to);
    tick();
    n_checks++; if (hits.size() !== 0) $display("FAIL nowrap_far_nhits: got %0d want 0", hits.size()); else n_pass++;
    set_spr(1, 255, 2, 1, 1);
    run_scan(1'b0, cyc, to);
    tick();
    n_checks++; if (hits.size() !== 1 || hits[0] !== {3'd0, 3'd1}) $display("FAIL nowrap_edge_pair: got n=%0d first=%0h want n=1 first=%0h", hits.size(), (hits.size() > 0) ? hits[0] : 6'h3f, {3'd0, 3'd1}); else n_pass++;
    n_checks++; if (hit_count !== 8'd1) $display("FAIL nowrap_count: got %0d want 1", hit_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    int w;
    int k;
    bit stable;
    for (int s = 0; s < 8; s++) set_spr(s, 20, 20, 4, 4);
    hits.delete();
    done_cnt  = 0;
    hit_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        w = 0;
        while (!hit_valid && w < 50) begin tick(); w++; end
        n_checks++; if (hit_valid !== 1'b1) $display("FAIL bp_valid_timeout: got %b want 1 pair %0d,%0d", hit_valid, i, j); else n_pass++;
        n_checks++; if ({hit_a, hit_b} !== {3'(i), 3'(j)}) $display("FAIL bp_pair: got %0d,%0d want %0d,%0d", hit_a, hit_b, i, j); else n_pass++;
        stable = 1'b1;
        for (int s = 0; s < 5; s++) begin
          tick();
          if (hit_valid !== 1'b1 || {hit_a, hit_b} !== {3'(i), 3'(j)}) stable = 1'b0;
        end
        n_checks++; if (!stable) $display("FAIL bp_stable: got unstable want held pair %0d,%0d", i, j); else n_pass++;
        hit_ready = 1'b1;
        tick();
        hit_ready = 1'b0;
        k++;
        n_checks++; if (hit_count !== 8'(k)) $display("FAIL bp_count: got %0d want %0d", hit_count, k); else n_pass++;
      end
    end
    repeat (3) tick();
    n_checks++; if (hits.size() !== 28) $display("FAIL bp_nhits: got %0d want 28", hits.size()); else n_pass++;
    n_checks++; if (hit_count !== 8'd28) $display("FAIL bp_final_count: got %0d want 28", hit_count); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else n_pass++;
    hit_ready = 1'b1;
  endtask

  task automatic test_start_while_busy();
    int cyc; bit to;
    clear_mem();
    run_scan(1'b1, cyc, to);
    n_checks++; if (to || cyc !== 99) $display("FAIL busy_start_latency: got %0d want 99", cyc); else n_pass++;
    tick();
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL busy_start_done_ignored: got %b want 00", {busy, done}); else n_pass++;
    start = 1'b0;
    set_spr(0, 10, 10, 8, 8);
    set_spr(3, 15, 12, 8, 8);
    run_scan(1'b1, cyc, to);
    tick();
    start = 1'b0;
    n_checks++; if (cyc !== 100 || hits.size() !== 1 || hits[0] !== {3'd0, 3'd3}) $display("FAIL busy_start_hits: got cyc=%0d n=%0d want cyc=100 n=1 pair 0,3", cyc, hits.size()); else n_pass++;
    n_checks++; if (hit_count !== 8'd1 || busy !== 1'b0) $display("FAIL busy_start_count: got %0d busy=%b want 1 busy=0", hit_count, busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_start_stay_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int w;
    for (int s = 0; s < 8; s++) set_spr(s, 20, 20, 4, 4);
    hit_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!hit_valid && w < 50) begin tick(); w++; end
    n_checks++; if (hit_valid !== 1'b1 || {hit_a, hit_b} !== {3'd0, 3'd1}) $display("FAIL rstmid_emit: got v=%b %0d,%0d want v=1 0,1", hit_valid, hit_a, hit_b); else n_pass++;
    hits.delete();
    done_cnt = 0;
    rst_n = 1'b0;
    tick();
    n_checks++; if ({busy, hit_valid} !== 2'b00) $display("FAIL rstmid_flags: got %b want 00", {busy, hit_valid}); else n_pass++;
    n_checks++; if (hit_count !== 8'd0) $display("FAIL rstmid_count: got %0d want 0", hit_count); else n_pass++;
    rst_n     = 1'b1;
    hit_ready = 1'b1;
    repeat (150) tick();
    n_checks++; if (done_cnt !== 0 || hits.size() !== 0 || busy !== 1'b0) $display("FAIL rstmid_quiet: got done=%0d hits=%0d busy=%b want 0 0 0", done_cnt, hits.size(), busy); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    done_cnt = 0;
    test_reset();
    test_overlap();
    test_touch_edge();
    test_no_wrap();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Sequential pairwise collision scanner over the sprite attribute table.
- On `start`, reads every unordered sprite pair (i<j) through a one-cycle-latency read port.
- Tests each pair for inclusive bounding-box overlap and streams each colliding pair out over a valid/ready interface.
- Sits between sprite attribute memory and game-logic response handling; one full scan per frame.

Parameters:
- N_SPRITES, 8, number of table entries scanned (>=2).
- IDX_W, $clog2(N_SPRITES), sprite index width.
- CNT_W, 8, hit counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin scan; accepted only in IDLE.
- busy  out  1  high from start acceptance until the done cycle inclusive.
- done  out  1  one-cycle pulse at end of scan.
- spr_rd  out  1  attribute read strobe.
- spr_addr  out  IDX_W  attribute read index.
- spr_data  in  32  {x[31:24], y[23:16], w[15:8], h[7:0]}, valid the cycle after spr_rd.
- hit_valid  out  1  colliding pair presented.
- hit_ready  in  1  consumer accepts pair.
- hit_a  out  IDX_W  lower index of colliding pair.
- hit_b  out  IDX_W  higher index of colliding pair.
- hit_count  out  CNT_W  hits emitted in the current/last scan.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state IDLE; busy, done, spr_rd, hit_valid = 0; spr_addr, hit_a, hit_b, hit_count = 0; index registers i, j = 0.
- FSM states: IDLE, RD_A, CAP_A, RD_B, CAP_B, CHK, EMIT, DONE.
- IDLE: on start, set i=0, j=1, clear hit_count, go to RD_A.
- RD_A: spr_rd=1, spr_addr=i, go to CAP_A.
- CAP_A: latch spr_data into A registers, go to RD_B.
- RD_B: spr_rd=1, spr_addr=j, go to CAP_B.
- CAP_B: latch spr_data into B registers, go to CHK.
- CHK: evaluate overlap from the A and B registers.
  - Hit: go to EMIT.
  - No hit: advance.
- EMIT: hit_valid=1, hit_a=i, hit_b=j, all held stable until hit_ready. On the handshake cycle, increment hit_count (saturating at 2^CNT_W-1) and advance.
- Advance:
  - If j<N_SPRITES-1: j++, go to RD_B.
  - Else if i<N_SPRITES-2: i++, j=i+1 (new i), go to RD_A.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Overlap arithmetic: edges computed 9-bit, x2=x+w, y2=y+h; no 8-bit wrap, so a sprite at x=250 with w=20 extends to 270.
  - h_ov = (A.x <= B.x2) && (B.x <= A.x2); v_ov likewise in y.
  - Hit = h_ov && v_ov && both sprites enabled. Touching edges count as a hit.
- Enable: a sprite with w==0 or h==0 is disabled and never hits.
- Latency:
  - 3 cycles per non-colliding pair; 3 cycles + handshake wait per colliding pair.
  - +2 cycles per A reload, +1 for DONE.
  - Full N=8 scan with no hits, measured start→done: 7×2 + 28×3 + 1 = 99 cycles.
- Ordering: pairs are emitted in (i, j) lexicographic order; each pair at most once; never i==j.
- start while busy: ignored, including during the DONE cycle.
- spr_data is sampled only in CAP_A/CAP_B and ignored otherwise.
- hit_count holds its value after the scan until the next accepted start.
- Reset mid-scan: immediate return to IDLE with reset values; a pending hit is dropped; no done pulse.

Decomposition:
- Shared package sprite_pkg:
  - typedef sprite_attr_t, a packed struct {x, y, w, h} of 8 bits each matching the spr_data layout.
  - Field width constant SPR_COORD_W=8.
  - Scanner state enum.
- Sub-module rect_overlap: purely combinational. Inputs: two sprite_attr_t. Output: hit, including the enable and 9-bit edge rules. Reusable by other blocks; the scanner instantiates it once on the A/B registers.

Test Plan:
- Overlap: sprite0={10,10,8,8}, sprite3={15,12,8,8}, all others disabled (w=0); start → one hit (0,3), hit_count=1, done pulse.
- Touching edge: s1={0,0,10,10}, s2={10,0,5,5} → hit (1,2); same with s2.x=11 → no hit, hit_count=0.
- No wrap: s0={250,0,20,4}, s1={5,0,4,4} → no hit. s1.x=260 is not representable; instead use s1={255,2,1,1} → hit (0,1).
- Backpressure: all 8 sprites identical {20,20,4,4}, hit_ready low for 5 cycles on each hit → 28 hits in lexicographic order, each held stable while stalled, hit_count=28.
- start asserted while busy and in the DONE cycle → ignored; scan order and count unchanged. With no hits, done occurs exactly 99 cycles after start.
- rst_n asserted during EMIT of pair (0,1) → next cycle busy=0, hit_valid=0, hit_count=0, and no done pulse.
